// File: rtl/axis_frame_seq_pkg.sv
// Shared types and constants for the frame sequencer: FSM states, default
// frame length and drop counter width.
package axis_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  localparam int DEF_LEN_DEFAULT = 800;
  localparam int DROP_CNT_W      = 16;

endpackage

// File: rtl/axis_frame_seq_if.sv
// Input-word, buffer-RAM and AXI-Stream handshake bundle of the sequencer.
// master = sequencer side, slave = surrounding environment side.
interface axis_frame_seq_if #(
  parameter int ADDR_W = 10
) ();

  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_waddr;
  logic              buf_re;
  logic [ADDR_W-1:0] buf_raddr;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;

  modport master (
    input  in_valid, in_last, m_axis_tready,
    output in_ready, buf_we, buf_waddr, buf_re, buf_raddr, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output in_valid, in_last, m_axis_tready,
    input  in_ready, buf_we, buf_waddr, buf_re, buf_raddr, m_axis_tvalid, m_axis_tlast
  );

endinterface

// File: rtl/axis_frame_seq_rd_stage.sv
// Drain-side read issue and tvalid/tlast output register; beats hold while
// the downstream stalls, and the RAM keeps its data because no read issues.
module axis_rd_stage #(
  parameter int ADDR_W = 10
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  input  logic [ADDR_W:0] rcnt,
  input  logic [ADDR_W:0] nwords,
  input  logic            tready,
  output logic            buf_re,
  output logic            tvalid,
  output logic            tlast
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic re_s;
  logic tvalid_q, tvalid_d;
  logic tlast_q, tlast_d;

  // Issue a read when words remain and the output slot is free or draining.
  always_comb begin
    re_s     = en & (rcnt < nwords) & (~tvalid_q | tready);
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    if (re_s) begin
      tvalid_d = 1'b1;
      tlast_d  = (rcnt == (nwords - CNT_ONE));
    end else if (tready) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end else begin
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
    end
  end

  // Output beat register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  assign buf_re = re_s;
  assign tvalid = tvalid_q;
  assign tlast  = tlast_q;

endmodule

// File: rtl/axis_frame_seq.sv
// Single-frame buffer sequencer: fill phase writes input words, drain phase
// streams them out. Optional drop counter: define AXIS_FRAME_SEQ_DROPCNT_EN.
module axis_frame_seq
  import axis_seq_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DEF_LEN = DEF_LEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_W:0]       cfg_len,
  axis_frame_seq_if.master      bus,
  output logic                  busy,
  output logic                  frame_done,
`ifdef AXIS_FRAME_SEQ_DROPCNT_EN
  output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
  output logic                  ovf
);

  localparam logic [ADDR_W:0] CNT_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] DEPTH_C   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] DEF_LEN_C = DEF_LEN[ADDR_W:0];

  function automatic logic [ADDR_W:0] eff_len(input logic [ADDR_W:0] c);
    if (c == CNT_ZERO)     eff_len = DEF_LEN_C;
    else if (c > DEPTH_C)  eff_len = DEPTH_C;
    else                   eff_len = c;
  endfunction

  seq_state_e      state_q, state_d;
  logic [ADDR_W:0] wcnt_q, wcnt_d;
  logic [ADDR_W:0] rcnt_q, rcnt_d;
  logic [ADDR_W:0] nwords_q, nwords_d;
  logic [ADDR_W:0] len_q, len_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic            ovf_q, ovf_d;
  logic            wr_en_s, drop_s, rd_re_s, last_acc_s, first_last_s;
  logic            tvalid_s, tlast_s;
  logic [ADDR_W:0] first_len_s;

  // Frame FSM next-state and counter updates.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    rcnt_d       = rcnt_q;
    nwords_d     = nwords_q;
    len_d        = len_q;
    frame_done_d = 1'b0;
    wr_en_s      = bus.in_valid & in_ready_q;
    drop_s       = bus.in_valid & ~in_ready_q;
    last_acc_s   = tvalid_s & bus.m_axis_tready & tlast_s;
    first_len_s  = eff_len(cfg_len);
    first_last_s = bus.in_last | (first_len_s == CNT_ONE);
    case (state_q)
      IDLE: begin
        if (wr_en_s) begin
          len_d  = first_len_s;
          wcnt_d = CNT_ONE;
          if (first_last_s) begin
            nwords_d = CNT_ONE;
            rcnt_d   = CNT_ZERO;
            state_d  = DRAIN;
          end else begin
            state_d  = FILL;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (wr_en_s) begin
          wcnt_d = wcnt_q + CNT_ONE;
          if (bus.in_last || ((wcnt_q + CNT_ONE) == len_q)) begin
            nwords_d = wcnt_q + CNT_ONE;
            rcnt_d   = CNT_ZERO;
            state_d  = DRAIN;
          end else begin
            state_d  = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      DRAIN: begin
        if (rd_re_s) rcnt_d = rcnt_q + CNT_ONE;
        else         rcnt_d = rcnt_q;
        if (last_acc_s) begin
          state_d      = IDLE;
          wcnt_d       = CNT_ZERO;
          frame_done_d = 1'b1;
        end else begin
          state_d      = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d != DRAIN);
    busy_d     = (state_d != IDLE);
    ovf_d      = ovf_q | drop_s;
  end

  // FSM state, counters and registered status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      wcnt_q       <= CNT_ZERO;
      rcnt_q       <= CNT_ZERO;
      nwords_q     <= CNT_ZERO;
      len_q        <= CNT_ZERO;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      rcnt_q       <= rcnt_d;
      nwords_q     <= nwords_d;
      len_q        <= len_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      ovf_q        <= ovf_d;
    end
  end

`ifdef AXIS_FRAME_SEQ_DROPCNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of words dropped while not ready.
  always_comb begin
    if (drop_s && (drop_cnt_q != {DROP_CNT_W{1'b1}})) drop_cnt_d = drop_cnt_q + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
    else                                              drop_cnt_d = drop_cnt_q;
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) drop_cnt_q <= {DROP_CNT_W{1'b0}};
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

  axis_rd_stage #(.ADDR_W(ADDR_W)) u_rd (
    .clk    (clk),
    .rstn   (rstn),
    .en     (state_q == DRAIN),
    .rcnt   (rcnt_q),
    .nwords (nwords_q),
    .tready (bus.m_axis_tready),
    .buf_re (rd_re_s),
    .tvalid (tvalid_s),
    .tlast  (tlast_s)
  );

  assign bus.in_ready      = in_ready_q;
  assign bus.buf_we        = wr_en_s;
  assign bus.buf_waddr     = wcnt_q[ADDR_W-1:0];
  assign bus.buf_re        = rd_re_s;
  assign bus.buf_raddr     = rcnt_q[ADDR_W-1:0];
  assign bus.m_axis_tvalid = tvalid_s;
  assign bus.m_axis_tlast  = tlast_s;
  assign busy              = busy_q;
  assign frame_done        = frame_done_q;
  assign ovf               = ovf_q;

endmodule

// File: tb/tb_axis_frame_seq.sv
// Directed and randomized frames against a frame-level model with a
// behavioural buffer RAM around the sequencer.
module tb_axis_frame_seq;

  localparam int ADDR_W  = 10;
  localparam int DEPTH   = 1024;
  localparam int DEF_LEN = 800;

  logic            clk;
  logic            rstn;
  logic [ADDR_W:0] cfg_len;
  logic            busy, frame_done, ovf;
`ifdef AXIS_FRAME_SEQ_DROPCNT_EN
  logic [15:0]     drop_cnt;
`endif

  axis_frame_seq_if #(.ADDR_W(ADDR_W)) bif ();

  axis_frame_seq #(.ADDR_W(ADDR_W), .DEF_LEN(DEF_LEN)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cfg_len    (cfg_len),
    .bus        (bif),
    .busy       (busy),
    .frame_done (frame_done),
`ifdef AXIS_FRAME_SEQ_DROPCNT_EN
    .drop_cnt   (drop_cnt),
`endif
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic [31:0] words [0:2047];

  always @(posedge clk) begin
    if (bif.buf_we) mem[bif.buf_waddr] <= wdata;
    if (bif.buf_re) rdata <= mem[bif.buf_raddr];
  end

  int   n_checks = 0;
  int   n_pass   = 0;
  logic exp_ovf  = 1'b0;
  int   exp_drops = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic end_checks();
    check("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
`ifdef AXIS_FRAME_SEQ_DROPCNT_EN
    check("drop_cnt", {16'd0, drop_cnt}, exp_drops);
`endif
  endtask

  task automatic run_frame(input int cfg, input int nsend, input int last_at,
                           input int rmode, input int rst_beat);
    int len, n, i, wr_idx, beat, cyc, end_cyc, first_tv, last_acc, prev_acc, limit;
    logic prev_stall, prev_tlast;
    logic [31:0] prev_data;
    bit done;
    len = (cfg == 0) ? DEF_LEN : ((cfg > DEPTH) ? DEPTH : cfg);
    n = len;
    if (last_at > 0 && last_at < n) n = last_at;
    for (int k = 0; k < nsend; k++) words[k] = $urandom;
    if (nsend > n) exp_ovf = 1'b1;
    exp_drops += nsend - n;
    cfg_len = cfg[ADDR_W:0];
    i = 0; wr_idx = 0; beat = 0; cyc = 0; end_cyc = -10; first_tv = -1;
    last_acc = -10; prev_acc = -10; prev_stall = 1'b0; prev_tlast = 1'b0;
    prev_data = 32'd0; done = 1'b0;
    limit = nsend + 4 * n + 100;
    while (!done && cyc < limit) begin
      bif.in_valid = (i < nsend);
      bif.in_last  = (i < nsend) && (i + 1 == last_at);
      wdata        = (i < nsend) ? words[i] : 32'd0;
      case (rmode)
        0:       bif.m_axis_tready = 1'b1;
        1:       bif.m_axis_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: bif.m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (bif.buf_we) begin
        check("waddr", {22'd0, bif.buf_waddr}, wr_idx);
        wr_idx++;
        if (wr_idx == n) end_cyc = cyc;
      end
      check("frame_done", {31'd0, frame_done}, {31'd0, (cyc == last_acc + 1)});
      if (cyc == last_acc + 1) begin
        check("in_ready_after", {31'd0, bif.in_ready}, 32'd1);
        check("busy_after", {31'd0, busy}, 32'd0);
        done = 1'b1;
      end
      if (prev_stall) begin
        check("hold_tvalid", {31'd0, bif.m_axis_tvalid}, 32'd1);
        check("hold_tlast", {31'd0, bif.m_axis_tlast}, {31'd0, prev_tlast});
        check("hold_data", rdata, prev_data);
      end
      if (bif.m_axis_tvalid && first_tv < 0) begin
        first_tv = cyc;
        check("latency", cyc, end_cyc + 2);
      end
      if (bif.m_axis_tvalid && bif.m_axis_tready) begin
        check("beat_data", rdata, words[beat]);
        check("beat_tlast", {31'd0, bif.m_axis_tlast}, {31'd0, (beat == n - 1)});
        if (rmode == 0 && beat > 0) check("bubble", cyc, prev_acc + 1);
        prev_acc = cyc;
        if (beat == n - 1) last_acc = cyc;
        beat++;
      end
      prev_stall = bif.m_axis_tvalid & ~bif.m_axis_tready;
      prev_tlast = bif.m_axis_tlast;
      prev_data  = rdata;
      if (rst_beat > 0 && beat == rst_beat) begin
        check("ovf_pre_rst", {31'd0, ovf}, {31'd0, exp_ovf});
        rstn = 1'b0;
        #1;
        check("rst_tvalid", {31'd0, bif.m_axis_tvalid}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, bif.in_ready}, 32'd1);
        exp_ovf = 1'b0;
        exp_drops = 0;
        bif.in_valid = 1'b0;
        bif.in_last  = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        return;
      end
      if (bif.in_valid) i++;
      cyc++;
      @(posedge clk);
      #1;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("nwrites", wr_idx, n);
    check("nbeats", beat, n);
    end_checks();
    bif.in_valid = 1'b0;
    bif.in_last  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rc, rl, rn, rs;
    rstn = 1'b0;
    cfg_len = '0;
    wdata = 32'd0;
    rdata = 32'd0;
    bif.in_valid = 1'b0;
    bif.in_last = 1'b0;
    bif.m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready0", {31'd0, bif.in_ready}, 32'd1);
    check("rst_tvalid0", {31'd0, bif.m_axis_tvalid}, 32'd0);
    check("rst_tlast0", {31'd0, bif.m_axis_tlast}, 32'd0);
    check("rst_busy0", {31'd0, busy}, 32'd0);
    check("rst_done0", {31'd0, frame_done}, 32'd0);
    check("rst_ovf0", {31'd0, ovf}, 32'd0);
    check("rst_buf_re0", {31'd0, bif.buf_re}, 32'd0);
    check("rst_buf_we0", {31'd0, bif.buf_we}, 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    run_frame(800, 800, 800, 0, 0);
    run_frame(800, 5, 5, 0, 0);
    run_frame(4, 6, 0, 0, 0);
    run_frame(1, 1, 0, 0, 0);
    run_frame(16, 16, 16, 1, 0);
    run_frame(10, 12, 0, 0, 7);
    run_frame(3, 3, 3, 0, 0);
    run_frame(0, 800, 0, 0, 0);
    run_frame(2000, 1024, 0, 0, 0);
    for (int t = 0; t < 6; t++) begin
      rc = $urandom_range(1, 40);
      rl = $urandom_range(0, rc);
      rn = (rl == 0) ? rc : rl;
      rs = rn + $urandom_range(0, rn);
      run_frame(rc, rs, rl, 2, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
